dmem_vec_arbiter: RTL and testbench

//  Shares the single 192-bit (6 x 32-bit word) read port of the data ROM between two requesters.

---
 rtl/dmem_vec_arbiter.sv | 173 +++++++++++++++++
 tb/tb_dmem_vec_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_vec_arbiter.sv
// Two-requester arbiter for the 6-word ROM read port, gated by the ROM load sequence.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); round-robin otherwise.
module dmem_vec_arbiter #(
  parameter int S         = 32,
  parameter int V         = 192,
  parameter int SIZE      = 30015,
  parameter int LOAD_WAIT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         switchStart,
  input  logic         req0,
  input  logic         req1,
  input  logic [S-1:0] addr0,
  input  logic [S-1:0] addr1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rvalid,
  output logic         rid,
  output logic         rerr,
  output logic [V-1:0] rdata,
  output logic [S-1:0] mem_addr,
  input  logic [V-1:0] mem_rd,
  output logic         ready,
  output logic [1:0]   dbg_state
);

  // Handshake: a requester holds req (and its addr) until it sees gnt; the request is
  // consumed on the rising edge where gnt=1. Responses carry no back-pressure: rvalid is
  // a one-cycle pulse tagged with rid.

  localparam int CW = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;
  localparam logic [S-1:0] LAST_OK = S'(SIZE - 6);

  typedef enum logic [1:0] {
    ST_UNLOADED  = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_ARB       = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    sync_q;
  logic          rise;

  logic          grant;
  logic          sel_id;
  logic [S-1:0]  sel_addr;
  logic          sel_err;
  logic          s1_valid;
  logic          s1_id;
  logic          s1_err;

  // sync_q[1] is the synchronized level; sync_q[2] is its previous value for edge detection.
  assign rise      = sync_q[1] & ~sync_q[2];
  assign ready     = (state == ST_ARB);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      state  <= ST_UNLOADED;
      cnt    <= '0;
    end else begin
      sync_q <= {sync_q[1:0], switchStart};
      state  <= state_d;
      cnt    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ST_UNLOADED: begin
        if (rise) begin
          state_d = ST_LOAD_WAIT;
          cnt_d   = CW'(LOAD_WAIT - 1);
        end
      end
      ST_LOAD_WAIT: begin
        if (rise) begin
          cnt_d = CW'(LOAD_WAIT - 1);
        end else if (cnt == '0) begin
          state_d = ST_ARB;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      ST_ARB: begin
        if (rise) begin
          state_d = ST_LOAD_WAIT;
          cnt_d   = CW'(LOAD_WAIT - 1);
        end
      end
      default: begin
        state_d = ST_UNLOADED;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == ST_ARB) begin
      gnt0 = req0;
      gnt1 = req1 & ~req0;
    end
  end
`else
  // last_gnt: 1 when requester 1 was granted most recently, so requester 0 wins the next tie.
  logic last_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == ST_ARB) begin
      if (req0 && req1) begin
        gnt0 = last_gnt;
        gnt1 = ~last_gnt;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end
`endif

  assign grant    = gnt0 | gnt1;
  assign sel_id   = gnt1;
  assign sel_addr = gnt1 ? addr1 : addr0;
  assign sel_err  = (sel_addr > LAST_OK);

  // A switchStart rise reloads the ROM, so anything already granted is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr <= '0;
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_err   <= 1'b0;
      rvalid   <= 1'b0;
      rid      <= 1'b0;
      rerr     <= 1'b0;
      rdata    <= '0;
    end else begin
      if (grant && !sel_err) begin
        mem_addr <= sel_addr;
      end
      s1_valid <= grant & ~rise;
      s1_id    <= sel_id;
      s1_err   <= sel_err;
      rvalid   <= s1_valid & ~rise;
      if (s1_valid) begin
        rid   <= s1_id;
        rerr  <= s1_err;
        rdata <= s1_err ? '0 : mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_vec_arbiter.sv
// Directed bench for dmem_vec_arbiter: load gating, single read, arbitration table,
// range bounds, flush on reload and asynchronous reset.
module tb_dmem_vec_arbiter;

  localparam int S         = 32;
  localparam int V         = 192;
  localparam int SIZE      = 30015;
  localparam int LOAD_WAIT = 16;
  localparam logic [S-1:0] A_LAST = 32'(SIZE - 6);
  localparam logic [S-1:0] A_OVER = 32'(SIZE - 5);

  logic         clk;
  logic         rst_n;
  logic         switchStart;
  logic         req0, req1;
  logic [S-1:0] addr0, addr1;
  logic         gnt0, gnt1;
  logic         rvalid, rid, rerr;
  logic [V-1:0] rdata;
  logic [S-1:0] mem_addr;
  logic [V-1:0] mem_rd;
  logic         ready;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  dmem_vec_arbiter #(.S(S), .V(V), .SIZE(SIZE), .LOAD_WAIT(LOAD_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .switchStart(switchStart),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid(rvalid), .rid(rid), .rerr(rerr),
    .rdata(rdata), .mem_addr(mem_addr), .mem_rd(mem_rd), .ready(ready),
    .dbg_state(dbg_state)
  );

  // ROM model: word k holds the value k.
  always_comb begin
    mem_rd = '0;
    for (int i = 0; i < 6; i++) mem_rd[S*i +: S] = mem_addr + 32'(i);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [V-1:0] exp_vec(input logic [S-1:0] base);
    logic [V-1:0] v;
    v = '0;
    for (int i = 0; i < 6; i++) v[S*i +: S] = base + 32'(i);
    return v;
  endfunction

  task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         req0, req1;
    logic [S-1:0] addr0, addr1;
    logic         gnt0, gnt1;
    logic         rvalid, rid, rerr;
    logic [S-1:0] rbase;
    logic [S-1:0] maddr;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic r1,
                              input logic [S-1:0] a0, input logic [S-1:0] a1,
                              input logic g0, input logic g1,
                              input logic rv, input logic ri, input logic re,
                              input logic [S-1:0] rb, input logic [S-1:0] ma);
    vec_t t;
    t.req0 = r0; t.req1 = r1; t.addr0 = a0; t.addr1 = a1;
    t.gnt0 = g0; t.gnt1 = g1; t.rvalid = rv; t.rid = ri; t.rerr = re;
    t.rbase = rb; t.maddr = ma;
    return t;
  endfunction

  vec_t tbl[14];

  initial begin
    rst_n = 1'b0; switchStart = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;

    tbl[0]  = mk(0, 1, 0,  200, 0, 1, 0, 0, 0, 0,   100);
    tbl[1]  = mk(1, 1, 10, 20,  1, 0, 0, 0, 0, 0,   200);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    tbl[2]  = mk(1, 1, 10, 20,  1, 0, 1, 1, 0, 200, 10);
    tbl[3]  = mk(1, 1, 10, 20,  1, 0, 1, 0, 0, 10,  10);
    tbl[4]  = mk(1, 1, 10, 20,  1, 0, 1, 0, 0, 10,  10);
    tbl[5]  = mk(0, 0, 0,  0,   0, 0, 1, 0, 0, 10,  10);
    tbl[6]  = mk(0, 0, 0,  0,   0, 0, 1, 0, 0, 10,  10);
    tbl[7]  = mk(0, 1, 0,  A_LAST, 0, 1, 0, 0, 0, 0, 10);
`else
    tbl[2]  = mk(1, 1, 10, 20,  0, 1, 1, 1, 0, 200, 10);
    tbl[3]  = mk(1, 1, 10, 20,  1, 0, 1, 0, 0, 10,  20);
    tbl[4]  = mk(1, 1, 10, 20,  0, 1, 1, 1, 0, 20,  10);
    tbl[5]  = mk(0, 0, 0,  0,   0, 0, 1, 0, 0, 10,  20);
    tbl[6]  = mk(0, 0, 0,  0,   0, 0, 1, 1, 0, 20,  20);
    tbl[7]  = mk(0, 1, 0,  A_LAST, 0, 1, 0, 0, 0, 0, 20);
`endif
    tbl[8]  = mk(0, 1, 0,  A_OVER, 0, 1, 0, 0, 0, 0, A_LAST);
    tbl[9]  = mk(0, 0, 0,  0,   0, 0, 1, 1, 0, A_LAST, A_LAST);
    tbl[10] = mk(0, 0, 0,  0,   0, 0, 1, 1, 1, 0,   A_LAST);
    tbl[11] = mk(1, 0, 32'hFFFF_FFFF, 0, 1, 0, 0, 0, 0, 0, A_LAST);
    tbl[12] = mk(0, 0, 0,  0,   0, 0, 0, 0, 0, 0,   A_LAST);
    tbl[13] = mk(0, 0, 0,  0,   0, 0, 1, 0, 1, 0,   A_LAST);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);       chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid", rvalid, 0);   chk("rst_rid", rid, 0);
    chk("rst_rerr", rerr, 0);       chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_ready", ready, 0);
    chk("rst_state", dbg_state, 0);
    next_cycle();
    rst_n = 1'b1;

    // No grant before the ROM is loaded
    req0 = 1'b1; addr0 = 100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gnt0_unloaded", gnt0, 0);
      next_cycle();
    end

    // switchStart rise: 2 sync cycles, 1 detect cycle, then LOAD_WAIT cycles of wait
    switchStart = 1'b1;
    for (int i = 0; i < 3 + LOAD_WAIT; i++) begin
      @(negedge clk);
      chk("ready_during_load", ready, 0);
      chk("gnt0_during_load", gnt0, 0);
      if (i >= 3) chk("state_load_wait", dbg_state, 1);
      next_cycle();
    end
    @(negedge clk);
    chk("ready_arb", ready, 1);
    chk("gnt0_first", gnt0, 1);
    chk("gnt1_first", gnt1, 0);
    next_cycle();
    req0 = 1'b0; switchStart = 1'b0;
    @(negedge clk);
    chk("single_rvalid_early", rvalid, 0);
    next_cycle();
    @(negedge clk);
    chk("single_rvalid", rvalid, 1);
    chk("single_rid", rid, 0);
    chk("single_rerr", rerr, 0);
    chk("single_rdata", rdata, exp_vec(100));
    next_cycle();

    // Arbitration and bounds table
    for (int r = 0; r < 14; r++) begin
      req0 = tbl[r].req0; req1 = tbl[r].req1;
      addr0 = tbl[r].addr0; addr1 = tbl[r].addr1;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt0", r), gnt0, tbl[r].gnt0);
      chk($sformatf("tbl%0d_gnt1", r), gnt1, tbl[r].gnt1);
      chk($sformatf("tbl%0d_rvalid", r), rvalid, tbl[r].rvalid);
      chk($sformatf("tbl%0d_mem_addr", r), mem_addr, tbl[r].maddr);
      if (tbl[r].rvalid) begin
        chk($sformatf("tbl%0d_rid", r), rid, tbl[r].rid);
        chk($sformatf("tbl%0d_rerr", r), rerr, tbl[r].rerr);
        chk($sformatf("tbl%0d_rdata", r), rdata,
            tbl[r].rerr ? '0 : exp_vec(tbl[r].rbase));
      end
      next_cycle();
    end
    req0 = 1'b0; req1 = 1'b0;

    // Flush: synchronized rise lands one cycle after a grant
    switchStart = 1'b1;
    next_cycle();
    req0 = 1'b1; addr0 = 50;
    @(negedge clk);
    chk("flush_gnt0", gnt0, 1);
    next_cycle();
    req0 = 1'b0;
    for (int i = 0; i < LOAD_WAIT + 2; i++) begin
      @(negedge clk);
      chk("flush_rvalid", rvalid, 0);
      chk("flush_ready", ready, (i == 0 || i == LOAD_WAIT + 1) ? 1'b1 : 1'b0);
      next_cycle();
    end

    // Asynchronous reset in the middle of traffic
    req0 = 1'b1; addr0 = 60;
    @(negedge clk);
    chk("pre_rst_gnt0", gnt0, 1);
    next_cycle();
    next_cycle();
    chk("pre_rst_rvalid", rvalid, 1);
    chk("pre_rst_rdata", rdata, exp_vec(60));
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt0", gnt0, 0);      chk("async_gnt1", gnt1, 0);
    chk("async_rvalid", rvalid, 0);  chk("async_rid", rid, 0);
    chk("async_rerr", rerr, 0);      chk("async_rdata", rdata, 0);
    chk("async_mem_addr", mem_addr, 0); chk("async_ready", ready, 0);
    chk("async_state", dbg_state, 0);
    switchStart = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_gnt0", gnt0, 0);
      chk("post_rst_state", dbg_state, 0);
      next_cycle();
    end
    req0 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
